// File: rtl/matrix_result_drain_if.sv
// Streaming output channel of the matrix result drain: one product element per
// valid/ready handshake, tagged with its row/column position and a last flag.
interface matrix_result_drain_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SIZE  = 4
);
    localparam int unsigned RowW = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [WIDTH-1:0] out_data;
    logic [RowW-1:0]  out_row;
    logic [RowW-1:0]  out_col;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output out_data,
        output out_row,
        output out_col,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_row,
        input  out_col,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/matrix_result_drain.sv
// Result drain for the systolic multiplier: times the compute window after a
// start pulse, snapshots the product matrix, then streams it out row-major.
module matrix_result_drain #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SIZE    = 4,
    parameter int unsigned LATENCY = 3 * SIZE - 1
) (
    input  logic                                 clock,
    input  logic                                 nreset,
    input  logic                                 start,
    input  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] prod_in,
    output logic                                 acc_clear,
    output logic                                 busy,
    output logic                                 done,
    matrix_result_drain_if.master                out_if
);
    localparam int unsigned Cells = SIZE * SIZE;
    localparam int unsigned RowW  = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned IdxW  = (Cells > 1) ? $clog2(Cells) : 1;
    localparam int unsigned CntW  = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        StIdle,
        StCompute,
        StDrain
    } state_e;

    state_e                               state_q, state_d;
    logic [CntW-1:0]                      cnt_q, cnt_d;
    logic [IdxW-1:0]                      idx_q, idx_d;
    logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] buf_q;
    logic                                 capture;
    logic                                 acc_clear_q, acc_clear_d;
    logic                                 done_q, done_d;
    logic [RowW-1:0]                      row_idx, col_idx;
    logic                                 draining;

    // Next-state: start is only honoured in IDLE; a transfer advances idx.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        capture     = 1'b0;
        acc_clear_d = 1'b0;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StCompute;
                    cnt_d       = '0;
                    acc_clear_d = 1'b1;
                end
            end
            StCompute: begin
                if (cnt_q == CntW'(LATENCY - 1)) begin
                    capture = 1'b1;
                    state_d = StDrain;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDrain: begin
                if (out_if.out_ready) begin
                    if (idx_q == IdxW'(Cells - 1)) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counters, pulse outputs and the snapshot buffer.
    always_ff @(posedge clock or posedge nreset) begin
        if (nreset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            buf_q       <= '0;
            acc_clear_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            acc_clear_q <= acc_clear_d;
            done_q      <= done_d;
            if (capture) begin
                buf_q <= prod_in;
            end
        end
    end

    // Output decode from registered state/idx/buffer only; zero outside DRAIN.
    always_comb begin
        draining         = (state_q == StDrain);
        row_idx          = RowW'(idx_q / IdxW'(SIZE));
        col_idx          = RowW'(idx_q % IdxW'(SIZE));
        busy             = (state_q != StIdle);
        acc_clear        = acc_clear_q;
        done             = done_q;
        out_if.out_valid = draining;
        out_if.out_data  = draining ? buf_q[row_idx][col_idx] : '0;
        out_if.out_row   = draining ? row_idx : '0;
        out_if.out_col   = draining ? col_idx : '0;
        out_if.out_last  = draining && (idx_q == IdxW'(Cells - 1));
    end
endmodule

// File: tb/tb_matrix_result_drain.sv
// Scoreboard bench for matrix_result_drain: the driver issues jobs, the
// monitor predicts every output cycle from a job-level model.
module tb_matrix_result_drain;
    localparam int WIDTH   = 16;
    localparam int SIZE    = 4;
    localparam int LATENCY = 3 * SIZE - 1;
    localparam int N       = SIZE * SIZE;

    logic                                 clock = 1'b0;
    logic                                 nreset;
    logic                                 start;
    logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] prod;
    logic                                 acc_clear;
    logic                                 busy;
    logic                                 done;

    matrix_result_drain_if #(.WIDTH(WIDTH), .SIZE(SIZE)) ob ();

    matrix_result_drain #(.WIDTH(WIDTH), .SIZE(SIZE), .LATENCY(LATENCY)) dut (
        .clock     (clock),
        .nreset    (nreset),
        .start     (start),
        .prod_in   (prod),
        .acc_clear (acc_clear),
        .busy      (busy),
        .done      (done),
        .out_if    (ob)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    typedef struct {
        logic [WIDTH-1:0] data;
        int               row;
        int               col;
        bit               last;
    } beat_t;

    beat_t q[$];
    bit    m_busy    = 1'b0;
    bit    m_drain   = 1'b0;
    int    m_start   = -100;
    int    exp_clear = -1;
    int    exp_done  = -1;

    // Monitor: compares this cycle's outputs, then advances the model for the next edge.
    always @(negedge clock) begin
        beat_t e;
        if (nreset) begin
            q.delete();
            m_busy    = 1'b0;
            m_drain   = 1'b0;
            exp_clear = -1;
            exp_done  = -1;
            check("reset_outputs", 64'({acc_clear, busy, done, ob.out_valid, ob.out_last,
                                        ob.out_data, ob.out_row, ob.out_col}), 64'd0);
        end else begin
            check("acc_clear", 64'(acc_clear), 64'(exp_clear == cyc));
            check("done", 64'(done), 64'(exp_done == cyc));
            check("busy", 64'(busy), 64'(m_busy));
            check("out_valid", 64'(ob.out_valid), 64'(m_drain));
            if (m_drain) begin
                if (q.size() == 0) begin
                    check("queue_underflow", 64'd1, 64'd0);
                    m_drain = 1'b0;
                end else begin
                    e = q[0];
                    check("out_data", 64'(ob.out_data), 64'(e.data));
                    check("out_row", 64'(ob.out_row), 64'(e.row));
                    check("out_col", 64'(ob.out_col), 64'(e.col));
                    check("out_last", 64'(ob.out_last), 64'(e.last));
                end
            end else begin
                check("out_last_idle", 64'(ob.out_last), 64'd0);
            end
            // Start is judged against the busy status of the upcoming edge.
            if (!m_busy && start) begin
                m_busy    = 1'b1;
                m_start   = cyc + 1;
                exp_clear = cyc + 1;
            end
            if (m_drain && ob.out_ready && q.size() > 0) begin
                e = q.pop_front();
                if (e.last) begin
                    m_drain  = 1'b0;
                    m_busy   = 1'b0;
                    exp_done = cyc + 1;
                end
            end
            if (m_busy && !m_drain && (cyc + 1 == m_start + LATENCY)) begin
                for (int r = 0; r < SIZE; r++) begin
                    for (int c = 0; c < SIZE; c++) begin
                        q.push_back('{prod[r][c], r, c, (r == SIZE - 1) && (c == SIZE - 1)});
                    end
                end
                m_drain = 1'b1;
            end
        end
    end

    task automatic set_pattern();
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                prod[r][c] = WIDTH'(16 * r + c);
    endtask

    task automatic rand_prod();
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                prod[r][c] = WIDTH'($urandom);
    endtask

    // rmode: 0 ready=1, 1 random, 2 scripted stall; pmode: 0 hold, 1 random, 2 random after capture.
    // Returns the number of edges after the start edge at which done was seen.
    task automatic job(input int rmode, input int pmode, input bit poke, output int k_done);
        int  k;
        int  v;
        bit  seen;
        start = 1'b1;
        step();
        k      = 0;
        v      = 0;
        seen   = 1'b0;
        k_done = -1;
        while (k < 400 && !seen) begin
            if (done) begin
                seen   = 1'b1;
                k_done = k;
            end
            start = poke && ((k == 5) ||
                             (ob.out_valid && ob.out_row == 2'd1 && ob.out_col == 2'd3));
            if (ob.out_valid) v++;
            case (rmode)
                0:       ob.out_ready = 1'b1;
                1:       ob.out_ready = 1'($urandom_range(0, 1));
                default: begin
                    ob.out_ready = ob.out_valid && ((v <= 3) || (v >= 9 && (v % 2) == 1));
                    if (ob.out_valid && v >= 4 && v <= 8) begin
                        check("stall_pos", 64'({ob.out_row, ob.out_col}), 64'd3);
                        check("stall_data", 64'(ob.out_data), 64'd3);
                    end
                end
            endcase
            if (pmode == 1 || (pmode == 2 && k >= LATENCY)) rand_prod();
            if (!seen) begin
                step();
                k++;
            end
        end
        start = 1'b0;
        if (!seen) check("job_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int k;
        bit hit;
        nreset       = 1'b1;
        start        = 1'b0;
        ob.out_ready = 1'b0;
        prod         = '0;
        step();
        step();
        nreset = 1'b0;
        step();

        // Fixed pattern, full throughput.
        set_pattern();
        job(0, 0, 1'b0, k);
        check("throughput_t1", 64'(k), 64'(LATENCY + N));

        // Operands change after the capture edge.
        set_pattern();
        job(0, 2, 1'b0, k);
        check("throughput_t2", 64'(k), 64'(LATENCY + N));

        // Scripted backpressure at element 3.
        set_pattern();
        job(2, 0, 1'b0, k);

        // Start pulses while busy must not disturb anything.
        set_pattern();
        job(0, 0, 1'b1, k);
        check("throughput_t4", 64'(k), 64'(LATENCY + N));

        // Reset mid-drain at element 9.
        set_pattern();
        start        = 1'b1;
        ob.out_ready = 1'b1;
        step();
        start = 1'b0;
        hit   = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (ob.out_valid && ob.out_row == 2'd2 && ob.out_col == 2'd1) hit = 1'b1;
            else step();
        end
        if (!hit) check("reach_idx9", 64'd0, 64'd1);
        nreset = 1'b1;
        #1;
        check("async_reset", 64'({acc_clear, busy, done, ob.out_valid, ob.out_last,
                                  ob.out_data, ob.out_row, ob.out_col}), 64'd0);
        step();
        step();
        nreset = 1'b0;
        step();
        job(0, 0, 1'b0, k);
        check("throughput_t5", 64'(k), 64'(LATENCY + N));

        // Back-to-back: second start lands in the done cycle.
        rand_prod();
        job(0, 1, 1'b0, k);
        job(0, 1, 1'b0, k);
        check("throughput_t6", 64'(k), 64'(LATENCY + N));

        // Randomised jobs with random backpressure.
        for (int j = 0; j < 6; j++) begin
            rand_prod();
            job(1, 1, 1'b0, k);
        end

        ob.out_ready = 1'b0;
        repeat (4) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
